// File: rtl/wrr_dispatcher_pkg.sv
// Shared types and sizing helpers for the weighted round-robin dispatcher.
package wrr_dispatcher_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

  // Weight field must hold WEIGHT_NUM itself, hence the extra bit.
  function automatic int wrr_ww(input int weight_num);
    return $clog2(weight_num) + 1;
  endfunction

  function automatic int wrr_iw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrr_clamp(input int w, input int max_w);
    return (w > max_w) ? max_w : w;
  endfunction

endpackage

// File: rtl/wrr_dispatcher_if.sv
// Beat stream, per-port outputs and weight programming of the WRR dispatcher.
interface wrr_dispatcher_if
  import wrr_dispatcher_pkg::*;
#(
  parameter int DW         = 8,
  parameter int ARB_NUM    = 8,
  parameter int WEIGHT_NUM = 8
);
  localparam int WW = wrr_ww(WEIGHT_NUM);
  localparam int IW = wrr_iw(ARB_NUM);

  // Handshake: a beat moves on a side in every cycle where both its valid
  // (iReq / oReq[p]) and its ready (oGnt / iGnt[p]) are high at the clock edge;
  // valid never waits for ready, and a raised valid holds its data until taken.
  logic                  iReq;
  logic                  oGnt;
  logic [DW-1:0]         iData;
  logic [ARB_NUM-1:0]    oReq;
  logic [ARB_NUM-1:0]    iGnt;
  logic [DW-1:0]         oData;
  logic [IW-1:0]         oSel;
  logic [ARB_NUM*WW-1:0] iWeight;
  logic                  iWeightLoad;
  buf_state_e            oState;

  modport master (
    output iReq, iData, iGnt, iWeight, iWeightLoad,
    input  oGnt, oReq, oData, oSel, oState
  );

  modport slave (
    input  iReq, iData, iGnt, iWeight, iWeightLoad,
    output oGnt, oReq, oData, oSel, oState
  );

endinterface

// File: rtl/wrr_dispatcher_next_ptr.sv
// Circular priority find: first set bit of mask_i at (INCLUSIVE) or strictly
// after start_i; strictly-after wraps all the way round to start_i itself last.
module wrr_dispatcher_next_ptr #(
  parameter int N         = 8,
  parameter int IW        = 3,
  parameter bit INCLUSIVE = 1'b1
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);
  localparam int OFF = INCLUSIVE ? 0 : 1;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < N; k++) begin
      int            j;
      logic [IW-1:0] jj;
      j = int'(start_i) + k + OFF;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!found_o && mask_i[jj]) begin
        found_o = 1'b1;
        idx_o   = jj;
      end
    end
  end

endmodule

// File: rtl/wrr_dispatcher.sv
// Weighted round-robin 1-to-N dispatcher with a one-entry output buffer;
// port i receives up to weight[i] consecutive beats per round.
module wrr_dispatcher
  import wrr_dispatcher_pkg::*;
#(
  parameter int DW         = 8,
  parameter int ARB_NUM    = 8,
  parameter int WEIGHT_NUM = 8,
  parameter int RST_WEIGHT = 1
) (
  input  logic              iClk,
  input  logic              iRst_n,
  wrr_dispatcher_if.slave   bus
);
  localparam int WW = wrr_ww(WEIGHT_NUM);
  localparam int IW = wrr_iw(ARB_NUM);

  buf_state_e         state_q, state_d;
  logic [DW-1:0]      data_q, data_d;
  logic [IW-1:0]      sel_q, sel_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [WW-1:0]      cnt_q, cnt_d;
  logic [WW-1:0]      weight_q [ARB_NUM];
  logic [WW-1:0]      weight_d [ARB_NUM];

  logic [ARB_NUM-1:0] nz_mask;
  logic               any_w;
  logic [IW-1:0]      sel;
  logic               nxt_found;
  logic [IW-1:0]      nxt_idx;
  logic               full;
  logic               drain;
  logic               gnt;
  logic               accept;
  logic [WW:0]        cnt_inc;

  always_comb begin
    nz_mask = '0;
    for (int i = 0; i < ARB_NUM; i++) nz_mask[i] = (weight_q[i] != '0);
  end

  // any_w doubles as "some port has a nonzero weight".
  wrr_dispatcher_next_ptr #(.N(ARB_NUM), .IW(IW), .INCLUSIVE(1'b1)) u_sel (
    .mask_i (nz_mask),
    .start_i(ptr_q),
    .found_o(any_w),
    .idx_o  (sel)
  );

  wrr_dispatcher_next_ptr #(.N(ARB_NUM), .IW(IW), .INCLUSIVE(1'b0)) u_nxt (
    .mask_i (nz_mask),
    .start_i(sel),
    .found_o(nxt_found),
    .idx_o  (nxt_idx)
  );

  assign full    = (state_q == ST_FULL);
  assign drain   = full && bus.iGnt[sel_q];
  assign gnt     = any_w && (!full || bus.iGnt[sel_q]);
  assign accept  = bus.iReq && gnt;
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    weight_d = weight_q;

    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (drain && !accept) state_d = ST_EMPTY;
    endcase

    if (accept) begin
      data_d = bus.iData;
      sel_d  = sel;
      if (cnt_inc >= {1'b0, weight_q[sel]}) begin
        cnt_d = '0;
        ptr_d = nxt_found ? nxt_idx : '0;
      end else begin
        cnt_d = cnt_inc[WW-1:0];
        ptr_d = sel;
      end
    end

    // A same-cycle load wins over the credit update above; sel already used old weights.
    if (bus.iWeightLoad) begin
      for (int i = 0; i < ARB_NUM; i++)
        weight_d[i] = WW'(wrr_clamp(int'(bus.iWeight[i*WW +: WW]), WEIGHT_NUM));
      cnt_d = '0;
      ptr_d = '0;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < ARB_NUM; i++) weight_q[i] <= WW'(RST_WEIGHT);
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      weight_q <= weight_d;
    end
  end

  // oReq derives from the registered state, so it drops with the async reset.
  always_comb begin
    bus.oReq = '0;
    for (int i = 0; i < ARB_NUM; i++) bus.oReq[i] = full && (sel_q == IW'(i));
  end

  assign bus.oGnt   = gnt;
  assign bus.oData  = data_q;
  assign bus.oSel   = sel_q;
  assign bus.oState = state_q;

endmodule

// File: tb/tb_wrr_dispatcher.sv
// Directed and short random checks of the WRR dispatcher with 4 ports.
module tb_wrr_dispatcher;
  import wrr_dispatcher_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wrr_dispatcher_if #(.DW(DW), .ARB_NUM(N), .WEIGHT_NUM(8)) bus ();

  wrr_dispatcher #(.DW(DW), .ARB_NUM(N), .WEIGHT_NUM(8), .RST_WEIGHT(1)) dut (
    .iClk  (clk),
    .iRst_n(rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];
  int port_cnt[N];

  int exp_rr[6]  = '{0, 1, 2, 3, 0, 1};
  int exp_w2[9]  = '{0, 0, 1, 3, 3, 3, 0, 0, 1};
  int exp_ld[6]  = '{0, 0, 0, 0, 1, 2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weights(input logic [15:0] w);
    bus.iWeight     = w;
    bus.iWeightLoad = 1'b1;
    tick();
    bus.iWeightLoad = 1'b0;
  endtask

  task automatic sample_random();
    logic [DW-1:0] d;
    check("rnd_onehot0", 32'($onehot0(bus.oReq)), 32'd1);
    check("rnd_valid", 32'(|bus.oReq), 32'(exp_q.size() != 0));
    check("rnd_gnt", 32'(bus.oGnt), 32'((exp_q.size() == 0) || bus.iGnt[bus.oSel]));
    if (|bus.oReq && bus.iGnt[bus.oSel]) begin
      if (exp_q.size() == 0) begin
        check("rnd_spurious", 32'(bus.oReq), 32'd0);
      end else begin
        d = exp_q.pop_front();
        check("rnd_data", 32'(bus.oData), 32'(d));
        port_cnt[bus.oSel]++;
      end
    end
    if (bus.iReq && bus.oGnt) exp_q.push_back(bus.iData);
  endtask

  initial begin
    int d03;
    int d13;
    bus.iReq = 1'b0; bus.iGnt = '0; bus.iData = '0;
    bus.iWeight = '0; bus.iWeightLoad = 1'b0;
    for (int p = 0; p < N; p++) port_cnt[p] = 0;

    // Reset state
    #2;
    check("rst_oreq", 32'(bus.oReq), 32'd0);
    check("rst_osel", 32'(bus.oSel), 32'd0);
    check("rst_odata", 32'(bus.oData), 32'd0);
    #10 rst_n = 1'b1;
    tick();
    check("rst_ognt", 32'(bus.oGnt), 32'd1);
    check("rst_state", 32'(bus.oState), 32'(ST_EMPTY));

    // Plain round-robin, full throughput
    for (int k = 0; k < 6; k++) begin
      bus.iReq = 1'b1; bus.iGnt = 4'hF; bus.iData = 8'(8'h10 + k);
      #1 check("rr_gnt", 32'(bus.oGnt), 32'd1);
      tick();
      check("rr_sel", 32'(bus.oSel), 32'(exp_rr[k]));
      check("rr_req", 32'(bus.oReq), 32'd1 << exp_rr[k]);
      check("rr_data", 32'(bus.oData), 32'(8'h10 + k));
    end
    check("rr_state", 32'(bus.oState), 32'(ST_FULL));
    bus.iReq = 1'b0;
    tick();
    check("rr_drain", 32'(bus.oReq), 32'd0);
    check("rr_empty", 32'(bus.oState), 32'(ST_EMPTY));

    // Weights {3,0,1,2} for ports 3..0
    load_weights(16'h3012);
    for (int k = 0; k < 9; k++) begin
      bus.iReq = 1'b1; bus.iData = 8'(8'h20 + k);
      tick();
      check("w_sel", 32'(bus.oSel), 32'(exp_w2[k]));
      check("w_req", 32'(bus.oReq), 32'd1 << exp_w2[k]);
      check("w_data", 32'(bus.oData), 32'(8'h20 + k));
    end

    // Port 1 holds off while its beat is buffered
    bus.iGnt = 4'b1101; bus.iData = 8'h30;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_gnt", 32'(bus.oGnt), 32'd0);
      check("stall_req", 32'(bus.oReq), 32'b0010);
      check("stall_data", 32'(bus.oData), 32'h28);
      tick();
    end
    bus.iGnt = 4'hF;
    #1 check("unstall_gnt", 32'(bus.oGnt), 32'd1);
    tick();
    check("unstall_sel", 32'(bus.oSel), 32'd3);
    check("unstall_data", 32'(bus.oData), 32'h30);

    // All weights zero with a beat buffered
    bus.iReq = 1'b0; bus.iGnt = 4'h0;
    load_weights(16'h0000);
    check("zw_req", 32'(bus.oReq), 32'b1000);
    check("zw_gnt_full", 32'(bus.oGnt), 32'd0);
    bus.iGnt = 4'hF; bus.iReq = 1'b1; bus.iData = 8'h31;
    #1 check("zw_gnt_drain", 32'(bus.oGnt), 32'd0);
    tick();
    check("zw_drained", 32'(bus.oReq), 32'd0);
    check("zw_gnt_empty", 32'(bus.oGnt), 32'd0);
    tick();
    check("zw_still_empty", 32'(bus.oReq), 32'd0);

    // Weight load coinciding with an accept at cnt=1 on port 0
    bus.iReq = 1'b0;
    load_weights(16'h1113);
    for (int k = 0; k < 6; k++) begin
      bus.iReq = 1'b1; bus.iData = 8'(8'h40 + k);
      bus.iWeight = 16'h1112; bus.iWeightLoad = (k == 1);
      tick();
      bus.iWeightLoad = 1'b0;
      check("ld_sel", 32'(bus.oSel), 32'(exp_ld[k]));
      check("ld_data", 32'(bus.oData), 32'(8'h40 + k));
    end

    // Async reset while a beat is buffered
    bus.iGnt = 4'h0; bus.iReq = 1'b0;
    #1 check("ar_pre_req", 32'(bus.oReq), 32'b0100);
    #1 rst_n = 1'b0;
    #1;
    check("ar_req", 32'(bus.oReq), 32'd0);
    check("ar_sel", 32'(bus.oSel), 32'd0);
    check("ar_data", 32'(bus.oData), 32'd0);
    check("ar_state", 32'(bus.oState), 32'(ST_EMPTY));
    #1 rst_n = 1'b1;
    tick();
    bus.iGnt = 4'hF; bus.iReq = 1'b1; bus.iData = 8'h60;
    tick();
    check("ar_sel0", 32'(bus.oSel), 32'd0);
    bus.iData = 8'h61;
    tick();
    check("ar_sel1", 32'(bus.oSel), 32'd1);
    bus.iReq = 1'b0;
    tick();
    check("ar_drain", 32'(bus.oReq), 32'd0);

    // Oversized weight on port 0 is clamped to 8
    load_weights(16'h111F);
    for (int k = 0; k < 9; k++) begin
      bus.iReq = 1'b1; bus.iData = 8'(8'h70 + k);
      tick();
      check("clamp_sel", 32'(bus.oSel), (k < 8) ? 32'd0 : 32'd1);
    end
    bus.iReq = 1'b0;
    tick();

    // Random traffic with weights {3,0,1,2}
    load_weights(16'h3012);
    for (int c = 0; c < 300; c++) begin
      bus.iReq  = 1'($urandom_range(0, 1));
      bus.iGnt  = 4'($urandom_range(0, 15));
      bus.iData = 8'($urandom_range(0, 255));
      #1;
      sample_random();
      tick();
    end
    bus.iReq = 1'b0; bus.iGnt = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      sample_random();
      tick();
    end
    check("rnd_all_drained", 32'(exp_q.size()), 32'd0);
    check("rnd_port2_zero", 32'(port_cnt[2]), 32'd0);
    d03 = port_cnt[0] * 3 - port_cnt[3] * 2;
    d13 = port_cnt[1] * 3 - port_cnt[3];
    check("rnd_ratio_0_3", 32'((d03 >= -6) && (d03 <= 6)), 32'd1);
    check("rnd_ratio_1_3", 32'((d13 >= -3) && (d13 <= 3)), 32'd1);
    check("rnd_progress", 32'(port_cnt[3] > 5), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
